// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared control indices, encodings, FSM states and vectors for the memory stage
package mem_stage_pkg;

   localparam int C_BUBBLE   = 0;
   localparam int C_READ     = 1;
   localparam int C_WRITE    = 2;
   localparam int C_SIZE_LO  = 3;
   localparam int C_SIZE_HI  = 4;
   localparam int C_UNSIGNED = 5;
   localparam int C_REGWRITE = 6;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_ABORT = 2'd2
   } state_t;

   localparam logic [4:0] DEF_VEC_MIS_LOAD  = 5'd4;
   localparam logic [4:0] DEF_VEC_MIS_STORE = 5'd5;
   localparam logic [4:0] DEF_VEC_BUSERR    = 5'd7;

   // Halfwords need an even address; words (and the unused 11 encoding) need word alignment.
   function automatic logic misaligned(input size_t size, input logic [1:0] lane);
      return size == SZ_H ? lane[0] : size == SZ_B ? 1'b0 : lane != 2'b00;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack bus between the memory stage and data memory
interface mem_stage_if;

   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, we, addr, wdata, be, input rdata, ack);
   modport slave  (input req, we, addr, wdata, be, output rdata, ack);

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-enable/store-data lane builder and little-endian load extractor
module mem_lane_align
   import mem_stage_pkg::*;
(
   input  size_t       size,
   input  logic [1:0]  lane,
   input  logic        load_unsigned,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

   // Stores replicate the datum over every lane so the byte enables alone pick the target bytes.
   assign be    = size == SZ_B ? 4'b0001 << lane : size == SZ_H ? 4'b0011 << {lane[1], 1'b0} : 4'hF;
   assign wdata = size == SZ_B ? {4{store_data[7:0]}} : size == SZ_H ? {2{store_data[15:0]}} : store_data;

   assign load_data = size == SZ_B ? {{24{!load_unsigned && byte_sel[7]}}, byte_sel} :
                      size == SZ_H ? {{16{!load_unsigned && half_sel[15]}}, half_sel} : rdata;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage issuing req/ack data accesses and registering the MEM/WB boundary
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int         TIMEOUT       = 255,
   parameter logic [4:0] VEC_MIS_LOAD  = DEF_VEC_MIS_LOAD,
   parameter logic [4:0] VEC_MIS_STORE = DEF_VEC_MIS_STORE,
   parameter logic [4:0] VEC_BUSERR    = DEF_VEC_BUSERR
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         control_in,
   input  logic [31:0]        alu_in,
   input  logic [31:0]        sw_in,
   input  logic [4:0]         regdst_in,
   input  logic [4:0]         vector_in,
   input  logic               mem_flush,
   mem_stage_if.master        dmem,
   output logic               mem_stall,
   output logic [31:0]        wb_data_out,
   output logic [4:0]         regdst_out,
   output logic               regwrite_out,
   output logic [4:0]         vector_out,
   output logic               valid_out
);

   logic        bubble;
   logic        rd;
   logic        wr;
   logic        reg_write;
   logic        load_unsigned;
   logic        mis;
   logic        mem_op;
   logic        timeout_hit;
   logic [31:0] load_data;
   logic [7:0]  cnt;
   size_t       size;
   state_t      state;

   assign bubble        = control_in[C_BUBBLE];
   assign rd            = control_in[C_READ];
   assign wr            = control_in[C_WRITE];
   assign reg_write     = control_in[C_REGWRITE];
   assign load_unsigned = control_in[C_UNSIGNED];
   assign size          = size_t'(control_in[C_SIZE_HI:C_SIZE_LO]);

   assign mis         = !bubble && (rd || wr) && misaligned(size, alu_in[1:0]);
   assign mem_op      = !bubble && (rd || wr) && vector_in == 5'd0 && !mis;
   assign timeout_hit = cnt == 8'(TIMEOUT - 1);

   assign dmem.req  = state != S_IDLE;
   assign dmem.we   = wr;
   assign dmem.addr = {alu_in[31:2], 2'b00};

   // Stall is gated by reset so an asserted reset releases upstream even with a memory op waiting.
   assign mem_stall = reset && (state == S_IDLE ? mem_op && !mem_flush : !(dmem.ack || timeout_hit));

   mem_lane_align u_align (
      .size          (size),
      .lane          (alu_in[1:0]),
      .load_unsigned (load_unsigned),
      .store_data    (sw_in),
      .rdata         (dmem.rdata),
      .be            (dmem.be),
      .wdata         (dmem.wdata),
      .load_data     (load_data)
   );

   // Access FSM plus MEM/WB register; a flushed access in flight still runs to ack/timeout in ABORT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         cnt          <= 8'd0;
         wb_data_out  <= 32'd0;
         regdst_out   <= 5'd0;
         regwrite_out <= 1'b0;
         vector_out   <= 5'd0;
         valid_out    <= 1'b0;
      end else begin
         regdst_out <= regdst_in;
         case (state)
            S_IDLE: begin
               cnt <= 8'd0;
               if (mem_op && !mem_flush) begin
                  state        <= S_BUSY;
                  wb_data_out  <= 32'd0;
                  regwrite_out <= 1'b0;
                  vector_out   <= 5'd0;
                  valid_out    <= 1'b0;
               end else begin
                  wb_data_out  <= mem_flush ? 32'd0 : alu_in;
                  regwrite_out <= !mem_flush && reg_write && !bubble && !mis;
                  vector_out   <= mem_flush ? 5'd0 : vector_in != 5'd0 ? vector_in :
                                  mis ? (rd ? VEC_MIS_LOAD : VEC_MIS_STORE) : 5'd0;
                  valid_out    <= !mem_flush && !bubble;
               end
            end
            S_BUSY: begin
               if (dmem.ack || timeout_hit) begin
                  state        <= S_IDLE;
                  cnt          <= 8'd0;
                  wb_data_out  <= mem_flush ? 32'd0 : dmem.ack && rd ? load_data : alu_in;
                  regwrite_out <= !mem_flush && dmem.ack && rd && reg_write;
                  vector_out   <= mem_flush || dmem.ack ? 5'd0 : VEC_BUSERR;
                  valid_out    <= !mem_flush;
               end else begin
                  cnt   <= cnt + 8'd1;
                  state <= mem_flush ? S_ABORT : S_BUSY;
               end
            end
            S_ABORT: begin
               if (dmem.ack || timeout_hit) begin
                  state        <= S_IDLE;
                  cnt          <= 8'd0;
                  wb_data_out  <= 32'd0;
                  regwrite_out <= 1'b0;
                  vector_out   <= 5'd0;
                  valid_out    <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a delayed-ack data memory model
module tb_mem_stage;
   import mem_stage_pkg::*;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        rw;
      logic [4:0]  vec;
      logic        valid;
   } res_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  control_in = 7'b1;
   logic [31:0] alu_in = 32'd0;
   logic [31:0] sw_in = 32'd0;
   logic [4:0]  regdst_in = 5'd0;
   logic [4:0]  vector_in = 5'd0;
   logic        mem_flush = 1'b0;
   logic        mem_stall;
   logic [31:0] wb_data_out;
   logic [4:0]  regdst_out;
   logic        regwrite_out;
   logic [4:0]  vector_out;
   logic        valid_out;

   int          checks = 0;
   int          errors = 0;
   int          ack_delay = 0;
   int          req_cnt = 0;
   int          commits = 0;
   logic [31:0] mem_rdata = 32'd0;
   res_t        exp_q[$];
   int          cyc, stalls, reqs;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata, bus_addr;

   mem_stage_if dmem();

   mem_stage #(.TIMEOUT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .control_in   (control_in),
      .alu_in       (alu_in),
      .sw_in        (sw_in),
      .regdst_in    (regdst_in),
      .vector_in    (vector_in),
      .mem_flush    (mem_flush),
      .dmem         (dmem),
      .mem_stall    (mem_stall),
      .wb_data_out  (wb_data_out),
      .regdst_out   (regdst_out),
      .regwrite_out (regwrite_out),
      .vector_out   (vector_out),
      .valid_out    (valid_out)
   );

   always #5 clk = ~clk;

   // Memory model: acks on the (ack_delay)-th request cycle, never when ack_delay is negative.
   always @(negedge clk) begin
      if (dmem.req) begin
         dmem.ack   = ack_delay >= 0 && req_cnt == ack_delay;
         dmem.rdata = mem_rdata;
         if (dmem.ack && dmem.we) commits++;
         req_cnt++;
      end else begin
         dmem.ack = 1'b0;
         req_cnt  = 0;
      end
   end

   function automatic logic [6:0] ctl(input bit rw, input bit uns, input bit [1:0] sz, input bit wr, input bit rdb);
      return {rw, uns, sz, wr, rdb, 1'b0};
   endfunction

   function automatic res_t got();
      return {wb_data_out, regdst_out, regwrite_out, vector_out, valid_out};
   endfunction

   task automatic issue(input logic [6:0] c, input logic [31:0] a, input logic [31:0] s, input logic [31:0] rdv,
                        input logic [4:0] r, input logic [4:0] v, input bit fl, input int dly, input res_t e);
      @(negedge clk);
      control_in = c;
      alu_in     = a;
      sw_in      = s;
      regdst_in  = r;
      vector_in  = v;
      mem_flush  = fl;
      mem_rdata  = rdv;
      ack_delay  = dly;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input string name);
      bit st;
      cyc = 0;
      stalls = 0;
      reqs = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         st = mem_stall;
         if (st) stalls++;
         if (dmem.req) begin
            reqs++;
            bus_we    = dmem.we;
            bus_be    = dmem.be;
            bus_wdata = dmem.wdata;
            bus_addr  = dmem.addr;
         end
         @(posedge clk);
         cyc++;
         if (!st) begin
            #1;
            return;
         end
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL %s stall never released within 40 cycles", name);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({got(), dmem.req, mem_stall} !== 46'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h req %b stall %b exp all zero", got(), dmem.req, mem_stall);
      end
      control_in = ctl(1, 0, 2'd2, 0, 1);
      alu_in = 32'h100;
      #1;
      checks++;
      if (mem_stall !== 1'b0 || dmem.req !== 1'b0) begin
         errors++;
         $display("FAIL reset_stall_gate stall %b req %b exp 0 0", mem_stall, dmem.req);
      end
      @(negedge clk);
      control_in = 7'b1;
      reset = 1'b1;
   endtask

   task automatic test_alu();
      logic [6:0]  c [3] = '{ctl(1, 0, 2'd0, 0, 0), 7'b1000001, ctl(0, 0, 2'd0, 0, 0)};
      logic [31:0] a [3] = '{32'h1234, 32'h55, 32'hFFFF_0000};
      logic [4:0]  v [3] = '{5'd3, 5'd0, 5'd0};
      res_t        e [3] = '{{32'h1234, 5'd5, 1'b1, 5'd3, 1'b1},
                             {32'h55, 5'd7, 1'b0, 5'd0, 1'b0},
                             {32'hFFFF_0000, 5'd0, 1'b0, 5'd0, 1'b1}};
      logic [4:0]  r [3] = '{5'd5, 5'd7, 5'd0};
      res_t        x;
      for (int i = 0; i < 3; i++) begin
         issue(c[i], a[i], 32'd0, 32'd0, r[i], v[i], 1'b0, 0, e[i]);
         wait_done("alu");
         x = exp_q.pop_front();
         checks++;
         if (got() !== x) begin
            errors++;
            $display("FAIL alu[%0d] result got %h exp %h", i, got(), x);
         end
         checks++;
         if (reqs != 0 || cyc != 1) begin
            errors++;
            $display("FAIL alu[%0d] timing reqs %0d cyc %0d exp 0 1", i, reqs, cyc);
         end
      end
   endtask

   task automatic test_load();
      logic [6:0]  c [6] = '{ctl(1, 0, 2'd0, 0, 1), ctl(1, 1, 2'd1, 0, 1), ctl(1, 0, 2'd1, 0, 1),
                             ctl(1, 1, 2'd0, 0, 1), ctl(1, 0, 2'd2, 0, 1), ctl(1, 0, 2'd3, 0, 1)};
      logic [31:0] a [6] = '{32'h103, 32'h102, 32'h100, 32'h101, 32'h104, 32'h108};
      logic [31:0] m [6] = '{32'h80FF_FF00, 32'hBEEF_1234, 32'h0000_8001, 32'h0000_AB00, 32'hDEAD_BEEF, 32'h1234_5678};
      int          d [6] = '{0, 0, 1, 0, 2, 0};
      logic [31:0] w [6] = '{32'hFFFF_FF80, 32'h0000_BEEF, 32'hFFFF_8001, 32'h0000_00AB, 32'hDEAD_BEEF, 32'h1234_5678};
      res_t        x;
      for (int i = 0; i < 6; i++) begin
         issue(c[i], a[i], 32'd0, m[i], 5'(i + 1), 5'd0, 1'b0, d[i], {w[i], 5'(i + 1), 1'b1, 5'd0, 1'b1});
         wait_done("load");
         x = exp_q.pop_front();
         checks++;
         if (got() !== x) begin
            errors++;
            $display("FAIL load[%0d] result got %h exp %h", i, got(), x);
         end
         checks++;
         if (cyc != 2 + d[i] || stalls != 1 + d[i] || reqs != 1 + d[i]) begin
            errors++;
            $display("FAIL load[%0d] timing cyc %0d stalls %0d reqs %0d exp %0d %0d %0d",
                     i, cyc, stalls, reqs, 2 + d[i], 1 + d[i], 1 + d[i]);
         end
         checks++;
         if (bus_addr !== {a[i][31:2], 2'b00} || bus_we !== 1'b0) begin
            errors++;
            $display("FAIL load[%0d] bus addr %h we %b exp %h 0", i, bus_addr, bus_we, {a[i][31:2], 2'b00});
         end
      end
   endtask

   task automatic test_misaligned();
      logic [6:0]  c [3] = '{ctl(1, 0, 2'd2, 0, 1), ctl(1, 0, 2'd1, 1, 0), ctl(1, 0, 2'd1, 0, 1)};
      logic [31:0] a [3] = '{32'h102, 32'h101, 32'h103};
      logic [4:0]  v [3] = '{5'd4, 5'd5, 5'd4};
      res_t        x;
      for (int i = 0; i < 3; i++) begin
         issue(c[i], a[i], 32'h99, 32'd0, 5'd8, 5'd0, 1'b0, 0, {a[i], 5'd8, 1'b0, v[i], 1'b1});
         wait_done("misaligned");
         x = exp_q.pop_front();
         checks++;
         if (got() !== x) begin
            errors++;
            $display("FAIL misaligned[%0d] result got %h exp %h", i, got(), x);
         end
         checks++;
         if (reqs != 0 || cyc != 1) begin
            errors++;
            $display("FAIL misaligned[%0d] bus reqs %0d cyc %0d exp 0 1", i, reqs, cyc);
         end
      end
   endtask

   task automatic test_store();
      logic [6:0]  c [4] = '{ctl(1, 0, 2'd0, 1, 0), ctl(1, 0, 2'd1, 1, 0), ctl(0, 0, 2'd2, 1, 0), ctl(0, 0, 2'd0, 1, 0)};
      logic [31:0] a [4] = '{32'h201, 32'h202, 32'h204, 32'h200};
      logic [31:0] s [4] = '{32'h55, 32'hABCD_1234, 32'hCAFE_F00D, 32'h1AB};
      logic [3:0]  b [4] = '{4'b0010, 4'b1100, 4'b1111, 4'b0001};
      logic [31:0] w [4] = '{32'h5555_5555, 32'h1234_1234, 32'hCAFE_F00D, 32'hABAB_ABAB};
      res_t        x;
      int          c0;
      for (int i = 0; i < 4; i++) begin
         c0 = commits;
         issue(c[i], a[i], s[i], 32'd0, 5'd10, 5'd0, 1'b0, 0, {a[i], 5'd10, 1'b0, 5'd0, 1'b1});
         wait_done("store");
         x = exp_q.pop_front();
         checks++;
         if (got() !== x) begin
            errors++;
            $display("FAIL store[%0d] result got %h exp %h", i, got(), x);
         end
         checks++;
         if (bus_be !== b[i] || bus_wdata !== w[i] || bus_we !== 1'b1) begin
            errors++;
            $display("FAIL store[%0d] bus be %b wdata %h we %b exp %b %h 1", i, bus_be, bus_wdata, bus_we, b[i], w[i]);
         end
         checks++;
         if (commits != c0 + 1 || bus_addr !== {a[i][31:2], 2'b00}) begin
            errors++;
            $display("FAIL store[%0d] commit %0d addr %h exp %0d %h", i, commits - c0, bus_addr, 1, {a[i][31:2], 2'b00});
         end
      end
   endtask

   task automatic test_timeout();
      res_t x;
      issue(ctl(1, 0, 2'd2, 0, 1), 32'h300, 32'd0, 32'd0, 5'd11, 5'd0, 1'b0, -1, {32'h300, 5'd11, 1'b0, 5'd7, 1'b1});
      wait_done("timeout");
      x = exp_q.pop_front();
      checks++;
      if (got() !== x) begin
         errors++;
         $display("FAIL timeout result got %h exp %h", got(), x);
      end
      checks++;
      if (reqs != 4 || stalls != 4 || cyc != 5) begin
         errors++;
         $display("FAIL timeout timing reqs %0d stalls %0d cyc %0d exp 4 4 5", reqs, stalls, cyc);
      end
      checks++;
      if (dmem.req !== 1'b0) begin
         errors++;
         $display("FAIL timeout req_after got %b exp 0", dmem.req);
      end
   endtask

   task automatic test_flush();
      res_t x;
      int   c0;
      issue(ctl(1, 0, 2'd2, 0, 1), 32'h100, 32'd0, 32'd0, 5'd12, 5'd0, 1'b1, 0, {32'd0, 5'd12, 1'b0, 5'd0, 1'b0});
      wait_done("flush_idle");
      x = exp_q.pop_front();
      checks++;
      if (got() !== x || reqs != 0) begin
         errors++;
         $display("FAIL flush_idle result got %h reqs %0d exp %h 0", got(), reqs, x);
      end
      c0 = commits;
      issue(ctl(0, 0, 2'd2, 1, 0), 32'h400, 32'h1122_3344, 32'd0, 5'd9, 5'd0, 1'b0, 2, {32'd0, 5'd9, 1'b0, 5'd0, 1'b0});
      @(posedge clk);
      @(negedge clk);
      mem_flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mem_flush = 1'b0;
      #1;
      checks++;
      if (dmem.req !== 1'b1 || mem_stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_abort hold req %b stall %b exp 1 1", dmem.req, mem_stall);
      end
      #1;
      wait_done("flush_busy");
      x = exp_q.pop_front();
      checks++;
      if (got() !== x) begin
         errors++;
         $display("FAIL flush_busy result got %h exp %h", got(), x);
      end
      checks++;
      if (commits != c0 + 1 || reqs != 2 || dmem.req !== 1'b0) begin
         errors++;
         $display("FAIL flush_busy commit %0d reqs %0d req_after %b exp 1 2 0", commits - c0, reqs, dmem.req);
      end
   endtask

   task automatic test_reset_mid_busy();
      @(negedge clk);
      control_in = ctl(1, 0, 2'd2, 0, 1);
      alu_in     = 32'h500;
      regdst_in  = 5'd13;
      ack_delay  = -1;
      @(posedge clk);
      #2;
      checks++;
      if (dmem.req !== 1'b1 || mem_stall !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy_pre req %b stall %b exp 1 1", dmem.req, mem_stall);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (dmem.req !== 1'b0 || mem_stall !== 1'b0 || got() !== 44'd0) begin
         errors++;
         $display("FAIL mid_busy_reset req %b stall %b out %h exp 0 0 0", dmem.req, mem_stall, got());
      end
      @(negedge clk);
      control_in = 7'b1;
      reset = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [6:0]  c [5] = '{ctl(1, 0, 2'd0, 0, 1), ctl(1, 0, 2'd0, 0, 0), ctl(0, 0, 2'd2, 1, 0),
                             ctl(1, 1, 2'd1, 0, 1), 7'b1};
      logic [31:0] a [5] = '{32'h103, 32'h77, 32'h208, 32'h102, 32'h9};
      logic [31:0] m [5] = '{32'h80FF_FF00, 32'd0, 32'd0, 32'hBEEF_1234, 32'd0};
      int          d [5] = '{0, 0, 1, 0, 0};
      res_t        e [5] = '{{32'hFFFF_FF80, 5'd1, 1'b1, 5'd0, 1'b1},
                             {32'h77, 5'd2, 1'b1, 5'd0, 1'b1},
                             {32'h208, 5'd3, 1'b0, 5'd0, 1'b1},
                             {32'h0000_BEEF, 5'd4, 1'b1, 5'd0, 1'b1},
                             {32'h9, 5'd5, 1'b0, 5'd0, 1'b0}};
      res_t        x;
      for (int i = 0; i < 5; i++) begin
         issue(c[i], a[i], 32'hCAFE_F00D, m[i], 5'(i + 1), 5'd0, 1'b0, d[i], e[i]);
         wait_done("b2b");
         x = exp_q.pop_front();
         checks++;
         if (got() !== x) begin
            errors++;
            $display("FAIL b2b[%0d] result got %h exp %h", i, got(), x);
         end
      end
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      test_reset();
      test_alu();
      test_load();
      test_misaligned();
      test_store();
      test_timeout();
      test_flush();
      test_reset_mid_busy();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
